laser_rx_frame_parser: RTL and testbench
========================================

Name: laser_rx_frame_parser

Overview:
- Sits directly downstream of the laser UART comm controller.
- Consumes its received byte stream (data, valid, last-on-0xFF) and assembles bytes into laser response frames.
- Validates frame structure, length and checksum; presents the decoded command and payload as one registered result.
- Reports malformed or stalled frames through an error pulse, error code and counters.

Parameters:
- TCQ, 0.1, simulation clock-to-Q delay on all register assignments.
- SOF_BYTE, 8'hAA, start-of-frame byte.
- MAX_PAYLOAD, 8, maximum payload byte count. Valid range 1..8.
- TIMEOUT_CYC, 20000, maximum gap between bytes inside a frame, in clk_i cycles (about 2.3 byte times at 100 MHz and 115200 baud).

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rst_i  in  1  synchronous active-high reset.
- laser_rx_data_i  in  8  received UART byte.
- laser_rx_vld_i  in  1  byte strobe, single cycle. There is no backpressure; every strobe must be consumed.
- laser_rx_last_i  in  1  qualifies the strobe; high when the byte is 0xFF.
- frame_vld_o  out  1  one-cycle pulse: a good frame was decoded.
- frame_cmd_o  out  8  command byte.
- frame_len_o  out  4  payload length.
- frame_payload_o  out  64  payload; payload byte k sits at [8k+7:8k]; unused bytes are 0.
- err_vld_o  out  1  one-cycle pulse: a frame was aborted.
- err_code_o  out  3  abort reason; held until the next error.
- frame_cnt_o  out  16  good-frame counter, saturating.
- err_cnt_o  out  16  error counter, saturating.

Behaviour:
- Frame format: SOF, CMD, LEN, N payload bytes (N = LEN), CHK, EOF (0xFF).
  - CHK = XOR of CMD, LEN and all payload bytes.
  - 0xFF is legal only in the EOF position.
- State machine: IDLE -> CMD -> LEN -> PAYLOAD -> CHK -> EOF -> IDLE.
  - States advance only on laser_rx_vld_i.
  - LEN = 0 goes from LEN straight to CHK.
  - PAYLOAD uses a 4-bit byte index; it leaves for CHK after byte index LEN-1.
- IDLE:
  - A byte equal to SOF_BYTE enters CMD.
  - Any other byte is dropped silently; no error, no count.
- Abort priority, evaluated on each accepted byte in CMD..CHK, highest first:
  - laser_rx_last_i high -> code 4, premature 0xFF.
  - In LEN only, byte > MAX_PAYLOAD -> code 1.
  - In CHK only, byte != running XOR -> code 2.
- In EOF, a byte != 0xFF -> code 3.
- Timeout:
  - Gap counter clears on every laser_rx_vld_i and counts while state != IDLE.
  - When it reaches TIMEOUT_CYC-1 with no strobe in that cycle, abort with code 5.
  - A strobe in the same cycle wins: the byte is processed and the counter clears.
- Any abort:
  - Return to IDLE.
  - The offending byte is never reinterpreted as SOF.
  - Assemble registers are cleared.
  - err_vld_o pulses in the cycle after the byte (or timeout), with err_code_o updated in that same cycle.
  - err_cnt_o increments, saturating at 0xFFFF.
- Good frame:
  - A valid EOF byte accepted in cycle T gives frame_vld_o = 1 in cycle T+1.
  - frame_cmd_o, frame_len_o and frame_payload_o update in that same cycle T+1 and hold until the next good frame.
  - Outputs are not disturbed by errors.
  - frame_cnt_o increments, saturating at 0xFFFF.
- The payload assembly register is zeroed on SOF, so short frames output zeros in their unused bytes.
- Reset:
  - All outputs are 0, state is IDLE, and counters, checksum and gap counter are 0.
  - Reset mid-frame discards the partial frame with no error pulse.
  - The first byte after reset release is evaluated in IDLE.
- frame_vld_o and err_vld_o are never high in the same cycle.

Test Plan:
- Bytes AA 01 02 10 20 33 FF, 1000-cycle spacing -> frame_vld_o for one cycle, one cycle after FF; cmd = 0x01, len = 2, payload = 0x...0000_2010; frame_cnt_o = 1; no err_vld_o.
- Same frame with CHK = 0x34 -> err_vld_o, code 2, err_cnt_o = 1; a following good frame AA 05 00 05 FF -> cmd = 0x05, len = 0, payload = 0.
- AA 01 09 ... -> code 1 after the LEN byte; the next bytes are dropped until the next AA.
- AA 01 FF -> code 4 on the FF byte; AA 01 00 01 00 -> code 3.
- AA 01, then silence -> err_vld_o exactly TIMEOUT_CYC cycles after the 01 strobe, code 5; also a strobe landing exactly on the timeout cycle -> no error.
- Junk 00 55 FF, then a good frame -> only frame_vld_o; rst_i pulse after AA 01 02 -> no pulses; next good frame decodes correctly with frame_cnt_o = 1.

Source files
------------

// File: rtl/laser_rx_frame_parser.sv
// Laser response frame parser.
// Assembles the byte stream from the laser UART controller into frames of the
// form SOF, CMD, LEN, payload[LEN], CHK, EOF(0xFF). Good frames are presented
// as one registered result. Malformed or stalled frames raise an error pulse
// with a reason code. Both outcomes are tallied in saturating counters.
module laser_rx_frame_parser #(
  parameter logic [7:0]  SOF_BYTE    = 8'hAA,
  parameter int unsigned MAX_PAYLOAD = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  laser_rx_data_i,
  input  logic        laser_rx_vld_i,
  input  logic        laser_rx_last_i,
  output logic        frame_vld_o,
  output logic [7:0]  frame_cmd_o,
  output logic [3:0]  frame_len_o,
  output logic [63:0] frame_payload_o,
  output logic        err_vld_o,
  output logic [2:0]  err_code_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned    GAP_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN  = 8'(MAX_PAYLOAD);

  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_EOF     = 3'd3;
  localparam logic [2:0] ERR_EARLY_FF = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_EOF     = 3'd5
  } state_t;

  // Running checksum update: XOR accumulation of one byte.
  function automatic logic [7:0] f_chk_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Saturating increment for the 16-bit event counters.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : (cnt + 16'd1);
  endfunction

  // Frame assembly state
  state_t             r_state;
  logic [7:0]         r_cmd;
  logic [3:0]         r_len;
  logic [3:0]         r_idx;
  logic [63:0]        r_pay;
  logic [7:0]         r_chk;
  logic [GAP_W-1:0]   r_gap;

  // Registered outputs
  logic               r_frame_vld;
  logic [7:0]         r_frame_cmd;
  logic [3:0]         r_frame_len;
  logic [63:0]        r_frame_payload;
  logic               r_err_vld;
  logic [2:0]         r_err_code;
  logic [15:0]        r_frame_cnt;
  logic [15:0]        r_err_cnt;

  // Next-state values
  state_t             w_state;
  logic [7:0]         w_cmd;
  logic [3:0]         w_len;
  logic [3:0]         w_idx;
  logic [63:0]        w_pay;
  logic [7:0]         w_chk;
  logic [GAP_W-1:0]   w_gap;
  logic               w_abort;
  logic [2:0]         w_abort_code;
  logic               w_good;

  // Next-state decode: frame walk, abort priority, inter-byte timeout.
  always_comb begin
    w_state      = r_state;
    w_cmd        = r_cmd;
    w_len        = r_len;
    w_idx        = r_idx;
    w_pay        = r_pay;
    w_chk        = r_chk;
    w_gap        = r_gap;
    w_abort      = 1'b0;
    w_abort_code = 3'd0;
    w_good       = 1'b0;

    if (laser_rx_vld_i) begin
      w_gap = {GAP_W{1'b0}};
    end else if (r_state != ST_IDLE) begin
      w_gap = r_gap + GAP_W'(1);
    end else begin
      w_gap = {GAP_W{1'b0}};
    end

    case (r_state)
      ST_IDLE: begin
        // Only SOF starts a frame; the assembly registers restart clean so
        // short frames report zeros in their unused payload bytes.
        if (laser_rx_vld_i && (laser_rx_data_i == SOF_BYTE)) begin
          w_state = ST_CMD;
          w_cmd   = 8'h00;
          w_len   = 4'd0;
          w_idx   = 4'd0;
          w_pay   = 64'd0;
          w_chk   = 8'h00;
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (!laser_rx_vld_i) begin
          w_state = ST_CMD;
        end else if (laser_rx_last_i) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_EARLY_FF;
        end else begin
          w_cmd   = laser_rx_data_i;
          w_chk   = f_chk_acc(8'h00, laser_rx_data_i);
          w_state = ST_LEN;
        end
      end

      ST_LEN: begin
        if (!laser_rx_vld_i) begin
          w_state = ST_LEN;
        end else if (laser_rx_last_i) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_EARLY_FF;
        end else if (laser_rx_data_i > MAX_LEN) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_LEN;
        end else begin
          w_len   = laser_rx_data_i[3:0];
          w_chk   = f_chk_acc(r_chk, laser_rx_data_i);
          w_idx   = 4'd0;
          w_state = (laser_rx_data_i == 8'h00) ? ST_CHK : ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (!laser_rx_vld_i) begin
          w_state = ST_PAYLOAD;
        end else if (laser_rx_last_i) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_EARLY_FF;
        end else begin
          w_pay[{r_idx[2:0], 3'b000} +: 8] = laser_rx_data_i;
          w_chk = f_chk_acc(r_chk, laser_rx_data_i);
          w_idx = r_idx + 4'd1;
          if (r_idx == (r_len - 4'd1)) begin
            w_state = ST_CHK;
          end else begin
            w_state = ST_PAYLOAD;
          end
        end
      end

      ST_CHK: begin
        if (!laser_rx_vld_i) begin
          w_state = ST_CHK;
        end else if (laser_rx_last_i) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_EARLY_FF;
        end else if (laser_rx_data_i != r_chk) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_CHK;
        end else begin
          w_state = ST_EOF;
        end
      end

      ST_EOF: begin
        if (!laser_rx_vld_i) begin
          w_state = ST_EOF;
        end else if (laser_rx_data_i == 8'hFF) begin
          w_good  = 1'b1;
          w_state = ST_IDLE;
        end else begin
          w_abort      = 1'b1;
          w_abort_code = ERR_EOF;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // A strobe in the final gap cycle wins over the timeout.
    if (!laser_rx_vld_i && (r_state != ST_IDLE) && (r_gap == GAP_LAST)) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_TIMEOUT;
    end else begin
      w_abort      = w_abort;
    end

    // Any abort drops back to IDLE without reinterpreting the offending byte.
    if (w_abort) begin
      w_state = ST_IDLE;
      w_cmd   = 8'h00;
      w_len   = 4'd0;
      w_idx   = 4'd0;
      w_pay   = 64'd0;
      w_chk   = 8'h00;
      w_gap   = {GAP_W{1'b0}};
    end else begin
      w_state = w_state;
    end
  end

  // State, assembly and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_cmd           <= 8'h00;
      r_len           <= 4'd0;
      r_idx           <= 4'd0;
      r_pay           <= 64'd0;
      r_chk           <= 8'h00;
      r_gap           <= {GAP_W{1'b0}};
      r_frame_vld     <= 1'b0;
      r_frame_cmd     <= 8'h00;
      r_frame_len     <= 4'd0;
      r_frame_payload <= 64'd0;
      r_err_vld       <= 1'b0;
      r_err_code      <= 3'd0;
      r_frame_cnt     <= 16'd0;
      r_err_cnt       <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_cmd       <= w_cmd;
      r_len       <= w_len;
      r_idx       <= w_idx;
      r_pay       <= w_pay;
      r_chk       <= w_chk;
      r_gap       <= w_gap;
      r_frame_vld <= w_good;
      r_err_vld   <= w_abort;
      if (w_good) begin
        r_frame_cmd     <= r_cmd;
        r_frame_len     <= r_len;
        r_frame_payload <= r_pay;
        r_frame_cnt     <= f_sat_inc(r_frame_cnt);
      end
      if (w_abort) begin
        r_err_code <= w_abort_code;
        r_err_cnt  <= f_sat_inc(r_err_cnt);
      end
    end
  end

  assign frame_vld_o     = r_frame_vld;
  assign frame_cmd_o     = r_frame_cmd;
  assign frame_len_o     = r_frame_len;
  assign frame_payload_o = r_frame_payload;
  assign err_vld_o       = r_err_vld;
  assign err_code_o      = r_err_code;
  assign frame_cnt_o     = r_frame_cnt;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_laser_rx_frame_parser.sv
// Directed testbench for laser_rx_frame_parser: a table of byte sequences with
// hand-computed results, plus hand-written timeout and reset sequences.
module tb_laser_rx_frame_parser;

  localparam int TMO = 20000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_last;
  logic        frame_vld;
  logic [7:0]  frame_cmd;
  logic [3:0]  frame_len;
  logic [63:0] frame_payload;
  logic        err_vld;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_cmp  = 0;
  int n_mis  = 0;
  int n_fv   = 0;
  int n_ev   = 0;
  int n_both = 0;

  laser_rx_frame_parser #(
    .SOF_BYTE    (8'hAA),
    .MAX_PAYLOAD (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .laser_rx_data_i (rx_data),
    .laser_rx_vld_i  (rx_vld),
    .laser_rx_last_i (rx_last),
    .frame_vld_o     (frame_vld),
    .frame_cmd_o     (frame_cmd),
    .frame_len_o     (frame_len),
    .frame_payload_o (frame_payload),
    .err_vld_o       (err_vld),
    .err_code_o      (err_code),
    .frame_cnt_o     (frame_cnt),
    .err_cnt_o       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts cycles each pulse is high, and any overlap.
  always @(negedge clk) begin
    if (frame_vld) n_fv++;
    if (err_vld) n_ev++;
    if (frame_vld && err_vld) n_both++;
  end

  typedef struct packed {
    logic [127:0] seq;    // bytes right-aligned, first byte leftmost
    int           nb;
    int           gap;
    int           fv_at;  // byte index followed by frame_vld, -1 none
    int           ev_at;  // byte index followed by err_vld, -1 none
    logic [2:0]   code;
    logic [7:0]   cmd;
    logic [3:0]   len;
    logic [63:0]  pay;
    logic [15:0]  fcnt;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [127:0] seq, input int nb, input int gap,
                              input int fv_at, input int ev_at, input logic [2:0] code,
                              input logic [7:0] cmd, input logic [3:0] len,
                              input logic [63:0] pay, input logic [15:0] fcnt,
                              input logic [15:0] ecnt);
    vec_t v;
    v.seq = seq; v.nb = nb; v.gap = gap; v.fv_at = fv_at; v.ev_at = ev_at;
    v.code = code; v.cmd = cmd; v.len = len; v.pay = pay; v.fcnt = fcnt; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Drive one byte for one cycle; return pulses seen the cycle after it.
  task automatic send_byte(input logic [7:0] d, output logic fv, output logic ev);
    @(negedge clk);
    rx_data = d;
    rx_vld  = 1'b1;
    rx_last = (d == 8'hFF);
    @(posedge clk);
    @(negedge clk);
    rx_vld  = 1'b0;
    rx_last = 1'b0;
    fv = frame_vld;
    ev = err_vld;
  endtask

  task automatic check_outs(input string nm, input logic [2:0] code, input logic [7:0] cmd,
                            input logic [3:0] len, input logic [63:0] pay,
                            input logic [15:0] fcnt, input logic [15:0] ecnt);
    check({nm, " err_code"},  64'(err_code),  64'(code));
    check({nm, " cmd"},       64'(frame_cmd), 64'(cmd));
    check({nm, " len"},       64'(frame_len), 64'(len));
    check({nm, " payload"},   frame_payload,  pay);
    check({nm, " frame_cnt"}, 64'(frame_cnt), 64'(fcnt));
    check({nm, " err_cnt"},   64'(err_cnt),   64'(ecnt));
  endtask

  task automatic apply(input vec_t v, input int id);
    int fv0, ev0;
    logic fv_s, ev_s;
    logic [7:0] d;
    fv0 = n_fv;
    ev0 = n_ev;
    for (int i = 0; i < v.nb; i++) begin
      d = v.seq[8*(v.nb-1-i) +: 8];
      send_byte(d, fv_s, ev_s);
      check($sformatf("v%0d b%0d frame_vld", id, i), 64'(fv_s), 64'(i == v.fv_at));
      check($sformatf("v%0d b%0d err_vld", id, i),   64'(ev_s), 64'(i == v.ev_at));
      repeat (v.gap) @(negedge clk);
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d frame pulses", id), 64'(n_fv - fv0), 64'((v.fv_at >= 0) ? 1 : 0));
    check($sformatf("v%0d err pulses", id),   64'(n_ev - ev0), 64'((v.ev_at >= 0) ? 1 : 0));
    check_outs($sformatf("v%0d", id), v.code, v.cmd, v.len, v.pay, v.fcnt, v.ecnt);
  endtask

  initial begin
    int   fv0, ev0, k;
    logic fv_s, ev_s;

    rst = 1'b1; rx_data = 8'h00; rx_vld = 1'b0; rx_last = 1'b0;

    vecs[0] = mk(128'({8'hAA,8'h01,8'h02,8'h10,8'h20,8'h33,8'hFF}), 7, 1000, 6, -1,
                 3'd0, 8'h01, 4'd2, 64'h2010, 16'd1, 16'd0);
    vecs[1] = mk(128'({8'hAA,8'h01,8'h02,8'h10,8'h20,8'h34,8'hFF}), 7, 3, -1, 5,
                 3'd2, 8'h01, 4'd2, 64'h2010, 16'd1, 16'd1);
    vecs[2] = mk(128'({8'hAA,8'h05,8'h00,8'h05,8'hFF}), 5, 3, 4, -1,
                 3'd2, 8'h05, 4'd0, 64'h0, 16'd2, 16'd1);
    vecs[3] = mk(128'({8'hAA,8'h01,8'h09,8'h33,8'h44,8'hAA,8'h02,8'h01,8'h07,8'h04,8'hFF}), 11, 3, 10, 2,
                 3'd1, 8'h02, 4'd1, 64'h07, 16'd3, 16'd2);
    vecs[4] = mk(128'({8'hAA,8'h01,8'hFF}), 3, 3, -1, 2,
                 3'd4, 8'h02, 4'd1, 64'h07, 16'd3, 16'd3);
    vecs[5] = mk(128'({8'hAA,8'h01,8'h00,8'h01,8'h00}), 5, 3, -1, 4,
                 3'd3, 8'h02, 4'd1, 64'h07, 16'd3, 16'd4);
    vecs[6] = mk(128'({8'h00,8'h55,8'hFF,8'hAA,8'h03,8'h03,8'h11,8'h22,8'h33,8'h00,8'hFF}), 11, 2, 10, -1,
                 3'd3, 8'h03, 4'd3, 64'h332211, 16'd4, 16'd4);
    vecs[7] = mk(128'({8'hAA,8'h7E,8'h08,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h7E,8'hFF}), 13, 1, 12, -1,
                 3'd3, 8'h7E, 4'd8, 64'h0807060504030201, 16'd5, 16'd4);
    vecs[8] = mk(128'({8'hAA,8'hAA,8'h01,8'hAA,8'h01,8'hFF}), 6, 1, 5, -1,
                 3'd3, 8'hAA, 4'd1, 64'hAA, 16'd6, 16'd4);
    vecs[9] = mk(128'({8'hAA,8'h01,8'h02,8'h10,8'hFF}), 5, 2, -1, 4,
                 3'd4, 8'hAA, 4'd1, 64'hAA, 16'd6, 16'd5);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst frame_vld", 64'(frame_vld), 64'(0));
    check("rst err_vld",   64'(err_vld),   64'(0));
    check_outs("rst", 3'd0, 8'h00, 4'd0, 64'h0, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], i);
    end

    // Silence after CMD: error exactly TMO edges after the strobe.
    ev0 = n_ev;
    send_byte(8'hAA, fv_s, ev_s);
    send_byte(8'h01, fv_s, ev_s);
    k = 0;
    ev_s = 1'b0;
    while (!ev_s && (k < TMO + 10)) begin
      @(posedge clk);
      #1;
      k++;
      ev_s = err_vld;
    end
    check("timeout latency", 64'(k), 64'(TMO));
    @(posedge clk);
    #1;
    check("timeout pulses", 64'(n_ev - ev0), 64'(1));
    check_outs("timeout", 3'd5, 8'hAA, 4'd1, 64'hAA, 16'd6, 16'd6);

    // Strobe landing on the last gap cycle: byte wins, no error.
    ev0 = n_ev;
    fv0 = n_fv;
    send_byte(8'hAA, fv_s, ev_s);
    send_byte(8'h01, fv_s, ev_s);
    repeat (TMO - 1) @(posedge clk);
    send_byte(8'h00, fv_s, ev_s);
    check("edge strobe err_vld", 64'(ev_s), 64'(0));
    send_byte(8'h01, fv_s, ev_s);
    send_byte(8'hFF, fv_s, ev_s);
    check("edge strobe frame_vld", 64'(fv_s), 64'(1));
    @(posedge clk);
    #1;
    check("edge strobe err pulses",   64'(n_ev - ev0), 64'(0));
    check("edge strobe frame pulses", 64'(n_fv - fv0), 64'(1));
    check_outs("edge strobe", 3'd5, 8'h01, 4'd0, 64'h0, 16'd7, 16'd6);

    // Reset mid-frame: partial frame discarded silently, all state cleared.
    ev0 = n_ev;
    fv0 = n_fv;
    send_byte(8'hAA, fv_s, ev_s);
    send_byte(8'h01, fv_s, ev_s);
    send_byte(8'h02, fv_s, ev_s);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid rst err pulses",   64'(n_ev - ev0), 64'(0));
    check("mid rst frame pulses", 64'(n_fv - fv0), 64'(0));
    check_outs("mid rst", 3'd0, 8'h00, 4'd0, 64'h0, 16'd0, 16'd0);
    apply(mk(128'({8'h02,8'hAA,8'h01,8'h02,8'h10,8'h20,8'h33,8'hFF}), 8, 2, 7, -1,
             3'd0, 8'h01, 4'd2, 64'h2010, 16'd1, 16'd0), 10);

    check("pulse overlap", 64'(n_both), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
